// File: rtl/program_memory.sv
`default_nettype none
// ============================================================================
// Module   : program_memory
// Purpose  : Writable instruction store. After reset it fills every word with
//            NOP_WORD. It then accepts a program streamed over a valid/ready
//            load port and serves instruction fetches with a registered
//            1-cycle read.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            fetch_req/addr     - fetch request from the program counter
//            fetch_valid/instr  - registered fetch result, one cycle later
//            load_start         - begin a new program load (READY only)
//            load_valid/last/data, load_ready - program word stream
//            load_count         - words accepted by the current/last load
//            load_err           - sticky overflow flag, cleared by load_start
//            mem_ready          - store is READY and serving fetches
// Revision : 1.0 - initial release
// ============================================================================
module program_memory #(
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err,
  output logic              mem_ready
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              load_err_q, load_err_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
  logic              load_ready_q, load_ready_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    load_count_d  = load_count_q;
    load_err_d    = load_err_q;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = NOP_WORD;

    case (state_q)
      ST_CLEAR: begin
        // One word per cycle; the pointer wraps back to zero on exit.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = NOP_WORD;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (fetch_req) begin
          fetch_instr_d = mem_q[fetch_addr];
          fetch_valid_d = 1'b1;
        end
        // A fetch in the same cycle as load_start is still served above.
        if (load_start) begin
          wr_ptr_d     = '0;
          load_count_d = '0;
          load_err_d   = 1'b0;
          state_d      = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (load_valid && load_ready_q) begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q;
          mem_wdata = load_data;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          if (load_count_q != FULL_CNT) begin
            load_count_d = load_count_q + 1'b1;
          end
          if (load_last) begin
            state_d = ST_READY;
          end else if (wr_ptr_q == LAST_ADDR) begin
            // Store is full but the stream did not end: flag overflow.
            state_d    = ST_READY;
            load_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // Registered copy of "next state is LOAD" so load_ready never depends
    // combinationally on load_valid.
    load_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      load_count_q  <= '0;
      load_err_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= NOP_WORD;
      load_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      load_count_q  <= load_count_d;
      load_err_q    <= load_err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      load_ready_q  <= load_ready_d;
    end
  end

  // Storage array has no reset; the CLEAR pass initialises it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign load_ready  = load_ready_q;
  assign load_count  = load_count_q;
  assign load_err    = load_err_q;
  assign mem_ready   = (state_q == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_program_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory
// Purpose  : Self-checking bench for program_memory (16 x 8 configuration).
//            A reference copy of the store is updated as load beats are
//            driven; expected fetch words are queued when a fetch is issued
//            and popped when the registered result appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory;

  logic       clk;
  logic       rst;
  logic       fetch_req;
  logic [3:0] fetch_addr;
  logic       fetch_valid;
  logic [7:0] fetch_instr;
  logic       load_start;
  logic       load_valid;
  logic       load_last;
  logic [7:0] load_data;
  logic       load_ready;
  logic [4:0] load_count;
  logic       load_err;
  logic       mem_ready;

  int         n_cmp;
  int         n_err;
  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];

  program_memory #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .NOP_WORD (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .load_err    (load_err),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch every address back-to-back and compare against the reference copy.
  task automatic test_fetch_readback(input string tag);
    logic [7:0] e;
    for (int a = 0; a < 16; a++) begin
      fetch_req  = 1'b1;
      fetch_addr = a[3:0];
      exp_q.push_back(ref_mem[a]);
      tick();
      n_cmp++;
      if (fetch_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s valid addr %0d: got %b expected 1", tag, a, fetch_valid);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (fetch_instr !== e) begin
          n_err++;
          $display("FAIL %s instr addr %0d: got %h expected %h", tag, a, fetch_instr, e);
        end
      end
    end
    fetch_req = 1'b0;
    tick();
    n_cmp++;
    if (fetch_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s valid after idle: got %b expected 0", tag, fetch_valid);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({mem_ready, fetch_valid, load_ready, load_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset flags: got %b expected 0000",
               {mem_ready, fetch_valid, load_ready, load_err});
    end
    n_cmp++;
    if (fetch_instr !== 8'h00 || load_count !== 5'd0) begin
      n_err++;
      $display("FAIL reset values: instr %h count %0d expected 00 / 0", fetch_instr, load_count);
    end
    rst = 1'b0;
    n = 0;
    while (mem_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL clear length: got %0d cycles expected 16", n);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    test_fetch_readback("clear");
  endtask

  task automatic test_load_basic();
    logic [7:0] words [5];
    words[0] = 8'h11; words[1] = 8'h92; words[2] = 8'h30;
    words[3] = 8'h23; words[4] = 8'hF0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b1 || mem_ready !== 1'b0 || load_count !== 5'd0) begin
      n_err++;
      $display("FAIL basic enter load: ready %b mem_ready %b count %0d expected 1/0/0",
               load_ready, mem_ready, load_count);
    end
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 4);
      n_cmp++;
      if (load_ready !== 1'b1) begin
        n_err++;
        $display("FAIL basic load_ready beat %0d: got %b expected 1", i, load_ready);
      end
      tick();
      ref_mem[i] = words[i];
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_cmp++;
    if (load_count !== 5'd5 || mem_ready !== 1'b1 || load_err !== 1'b0 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic end: count %0d mem_ready %b err %b ready %b expected 5/1/0/0",
               load_count, mem_ready, load_err, load_ready);
    end
    test_fetch_readback("basic");
  endtask

  task automatic test_load_stall();
    logic [7:0] words [6];
    int         idx;
    int         c;
    logic       v;
    for (int i = 0; i < 6; i++) words[i] = 8'hC1 + 8'(i);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    idx = 0;
    c   = 0;
    while (idx < 6 && c < 200) begin
      v = (c < 4) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      load_valid = v;
      load_data  = v ? words[idx] : 8'($urandom);
      load_last  = (idx == 5);
      n_cmp++;
      if (load_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stall load_ready cycle %0d: got %b expected 1", c, load_ready);
      end
      tick();
      if (v) begin
        ref_mem[idx] = words[idx];
        idx++;
      end
      c++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_cmp++;
    if (idx != 6) begin
      n_err++;
      $display("FAIL stall budget: sent %0d words expected 6", idx);
    end
    n_cmp++;
    if (load_count !== 5'd6 || mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall end: count %0d mem_ready %b expected 6/1", load_count, mem_ready);
    end
    test_fetch_readback("stall");
  endtask

  task automatic test_overflow();
    logic exp_ready;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h40 + 8'(i);
      load_last  = 1'b0;
      exp_ready  = (i < 16);
      n_cmp++;
      if (load_ready !== exp_ready) begin
        n_err++;
        $display("FAIL overflow load_ready beat %0d: got %b expected %b", i, load_ready, exp_ready);
      end
      tick();
      if (i < 16) ref_mem[i] = 8'h40 + 8'(i);
    end
    load_valid = 1'b0;
    n_cmp++;
    if (load_count !== 5'd16 || load_err !== 1'b1 || mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL overflow end: count %0d err %b mem_ready %b expected 16/1/1",
               load_count, load_err, mem_ready);
    end
    test_fetch_readback("overflow");
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++;
    if (load_err !== 1'b0 || load_count !== 5'd0 || load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL overflow restart: err %b count %0d ready %b expected 0/0/1",
               load_err, load_count, load_ready);
    end
    load_valid = 1'b1;
    load_data  = 8'h5A;
    load_last  = 1'b1;
    tick();
    ref_mem[0] = 8'h5A;
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_cmp++;
    if (load_count !== 5'd1 || mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL overflow single: count %0d mem_ready %b expected 1/1", load_count, mem_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] addrs [3];
    logic [7:0] e;
    addrs[0] = 4'd15; addrs[1] = 4'd0; addrs[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = addrs[i];
      exp_q.push_back(ref_mem[addrs[i]]);
      tick();
      n_cmp++;
      if (fetch_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b valid %0d: got %b expected 1", i, fetch_valid);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (fetch_instr !== e) begin
          n_err++;
          $display("FAIL b2b instr %0d: got %h expected %h", i, fetch_instr, e);
        end
      end
    end
    fetch_req = 1'b0;
    tick();
    n_cmp++;
    if (fetch_valid !== 1'b0 || fetch_instr !== ref_mem[15]) begin
      n_err++;
      $display("FAIL b2b hold: valid %b instr %h expected 0 / %h", fetch_valid, fetch_instr, ref_mem[15]);
    end
  endtask

  task automatic test_fetch_in_load();
    logic [7:0] e;
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 4'd3;
    exp_q.push_back(ref_mem[3]);
    tick();
    load_start = 1'b0;
    n_cmp++;
    if (fetch_valid !== 1'b1 || load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start+fetch: valid %b ready %b expected 1/1", fetch_valid, load_ready);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (fetch_instr !== e) begin
        n_err++;
        $display("FAIL start+fetch instr: got %h expected %h", fetch_instr, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 4'(i + 7);
      tick();
      n_cmp++;
      if (fetch_valid !== 1'b0 || mem_ready !== 1'b0) begin
        n_err++;
        $display("FAIL fetch in load %0d: valid %b mem_ready %b expected 0/0", i, fetch_valid, mem_ready);
      end
    end
    load_valid = 1'b1;
    load_data  = 8'h77;
    load_last  = 1'b1;
    tick();
    ref_mem[0] = 8'h77;
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    n_cmp++;
    if (fetch_valid !== 1'b0 || mem_ready !== 1'b1 || load_count !== 5'd1) begin
      n_err++;
      $display("FAIL fetch in load end: valid %b mem_ready %b count %0d expected 0/1/1",
               fetch_valid, mem_ready, load_count);
    end
    test_fetch_readback("after_load_fetch");
  endtask

  task automatic test_reset_mid_load();
    int n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hE1 + 8'(i);
      load_last  = 1'b0;
      tick();
    end
    n_cmp++;
    if (load_count !== 5'd3) begin
      n_err++;
      $display("FAIL midload count: got %0d expected 3", load_count);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (mem_ready !== 1'b0 || load_ready !== 1'b0 || load_count !== 5'd0 || load_err !== 1'b0
        || fetch_instr !== 8'h00) begin
      n_err++;
      $display("FAIL midload reset: mem_ready %b ready %b count %0d err %b instr %h expected 0/0/0/0/00",
               mem_ready, load_ready, load_count, load_err, fetch_instr);
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    n = 0;
    while (mem_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL midload clear length: got %0d expected 16", n);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    test_fetch_readback("midload");
    n_cmp++;
    if (load_count !== 5'd0) begin
      n_err++;
      $display("FAIL midload final count: got %0d expected 0", load_count);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 4'd0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'h00;

    test_reset();
    test_load_basic();
    test_load_stall();
    test_overflow();
    test_back_to_back();
    test_fetch_in_load();
    test_reset_mid_load();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
